one_to_four_demux: RTL

Registered 1-to-4 demultiplexer with valid/ready flow control: one input stream carrying a 2-bit destination select is split into four independent output channels. It is the distribution-side counterpart of the datapath's 4-to-1 select logic, used where one producer (e.g. write-back or a bus master) feeds one of four consumers. Each output channel has a 2-entry FIFO, so a stalled consumer blocks only traffic addressed to it.

---
 rtl/one_to_four_demux.sv | 93 +++++++++
 1 files changed

// File: rtl/one_to_four_demux.sv
// rtl/one_to_four_demux.sv - registered 1-to-4 demux with a 2-entry FIFO per output channel
// A stalled consumer only blocks traffic addressed to its own channel.

module one_to_four_demux_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            last_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // An empty channel keeps presenting the last entry it delivered.
    assign head = (count != 2'd0) ? mem[rd_ptr] : last_q;

endmodule

module one_to_four_demux #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic               busy
);

    logic [3:0][1:0] count;
    logic [3:0]      push;
    logic [3:0]      pop;
    logic            accept;

    // Ready looks only at registered occupancy, so no path runs from out_ready to in_ready.
    assign in_ready = (count[in_sel] != 2'd2);
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_chan
        assign push[k]      = accept && (in_sel == 2'(k));
        assign pop[k]       = out_valid[k] & out_ready[k];
        assign out_valid[k] = (count[k] != 2'd0);

        one_to_four_demux_chan #(.WIDTH(WIDTH)) u_chan (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (pop[k]),
            .wdata (in_data),
            .count (count[k]),
            .head  (out_data[k*WIDTH +: WIDTH])
        );
    end

    assign busy = |out_valid;

endmodule
